// File: rtl/fpu_pkg.sv
// Shared widths, class-flag indices and operand structs for the unpack/normalize path.
package fpu_pkg;
  localparam int EW  = 11;
  localparam int FW  = 53;
  localparam int LZW = 6;
  localparam int XW  = EW + 2;

  localparam int FL_ZERO = 0;
  localparam int FL_INF  = 1;
  localparam int FL_QNAN = 2;
  localparam int FL_SNAN = 3;

  typedef struct packed {
    logic           s;
    logic [EW-1:0]  e;
    logic [LZW-1:0] lz;
    logic [FW-1:0]  f;
    logic [3:0]     fl;
  } unpacked_op_t;

  typedef struct packed {
    logic           s;
    logic [XW-1:0]  x;
    logic [FW-1:0]  f;
    logic [3:0]     fl;
  } norm_op_t;

  function automatic logic is_special(input logic [3:0] fl);
    return fl[FL_INF] | fl[FL_QNAN] | fl[FL_SNAN];
  endfunction

  // Operand that actually needs a left shift: finite, nonzero, leading zeros present.
  function automatic logic is_subnorm(input unpacked_op_t op);
    return !op.fl[FL_ZERO] && !is_special(op.fl) && (op.lz != '0);
  endfunction
endpackage

// File: rtl/norm_shift.sv
// Combinational per-operand normalizer: clamps lz, left-shifts the significand, rebases exponent.
module norm_shift
  import fpu_pkg::*;
(
  input  unpacked_op_t op_i,
  output norm_op_t     op_o
);
  logic [LZW-1:0] lz_c;

  always_comb begin
    lz_c    = (op_i.lz > LZW'(FW-1)) ? LZW'(FW-1) : op_i.lz;
    op_o.s  = op_i.s;
    op_o.fl = op_i.fl;
    op_o.x  = '0;
    op_o.f  = '0;
    if (op_i.fl[FL_ZERO]) begin
      op_o.x = '0;
      op_o.f = '0;
    end else if (is_special(op_i.fl)) begin
      op_o.x = {2'b00, op_i.e};
      op_o.f = op_i.f;
    end else begin
      // Exponent goes negative for deep subnormals; two's complement in XW bits.
      op_o.x = {2'b00, op_i.e} - XW'(lz_c);
      op_o.f = op_i.f << lz_c;
    end
  end
endmodule

// File: rtl/unpack_normalizer.sv
// Two-stage valid/ready normalizer for unpacked A/B operand pairs.
// Optional UNPACK_NORM_STATS_EN adds a saturating subnormal-operand counter output sub_cnt.
module unpack_normalizer
  import fpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            db,
  input  logic            sa,
  input  logic            sb,
  input  logic [EW-1:0]   ea,
  input  logic [EW-1:0]   eb,
  input  logic [LZW-1:0]  lza,
  input  logic [LZW-1:0]  lzb,
  input  logic [FW-1:0]   fa,
  input  logic [FW-1:0]   fb,
  input  logic [3:0]      fla,
  input  logic [3:0]      flb,
  input  logic [FW-1:0]   nan,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            db_o,
  output logic            sa_o,
  output logic            sb_o,
  output logic [XW-1:0]   xa_o,
  output logic [XW-1:0]   xb_o,
  output logic [FW-1:0]   fa_o,
  output logic [FW-1:0]   fb_o,
  output logic [3:0]      fla_o,
  output logic [3:0]      flb_o,
  output logic [FW-1:0]   nan_o
`ifdef UNPACK_NORM_STATS_EN
  ,
  output logic [31:0]     sub_cnt
`endif
);
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic s1_adv, s2_adv, in_fire;
  logic s1_db_q, s2_db_q;
  logic [FW-1:0] s1_nan_q, s2_nan_q;
  unpacked_op_t [1:0] in_op, s1_op_q;
  norm_op_t     [1:0] nrm, s2_op_q;

  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = s1_v_q && s2_adv;
  assign in_ready = !s1_v_q || s1_adv;
  assign in_fire  = in_valid && in_ready;

  assign in_op[0] = '{sa, ea, lza, fa, fla};
  assign in_op[1] = '{sb, eb, lzb, fb, flb};

  for (genvar g = 0; g < 2; g++) begin : g_op
    norm_shift u_ns (.op_i(s1_op_q[g]), .op_o(nrm[g]));
  end

  always_comb begin
    s1_v_d = s1_v_q;
    s2_v_d = s2_v_q;
    if (in_ready) s1_v_d = in_valid;
    if (s2_adv)   s2_v_d = s1_v_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s1_db_q  <= 1'b0;
      s2_db_q  <= 1'b0;
      s1_nan_q <= '0;
      s2_nan_q <= '0;
      s1_op_q  <= '0;
      s2_op_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      if (in_fire) begin
        s1_op_q  <= in_op;
        s1_db_q  <= db;
        s1_nan_q <= nan;
      end
      // S2 payload only moves on a real transfer, so it holds while stalled.
      if (s1_adv) begin
        s2_op_q  <= nrm;
        s2_db_q  <= s1_db_q;
        s2_nan_q <= s1_nan_q;
      end
    end
  end

  assign out_valid = s2_v_q;
  assign db_o      = s2_db_q;
  assign nan_o     = s2_nan_q;
  assign sa_o      = s2_op_q[0].s;
  assign xa_o      = s2_op_q[0].x;
  assign fa_o      = s2_op_q[0].f;
  assign fla_o     = s2_op_q[0].fl;
  assign sb_o      = s2_op_q[1].s;
  assign xb_o      = s2_op_q[1].x;
  assign fb_o      = s2_op_q[1].f;
  assign flb_o     = s2_op_q[1].fl;

`ifdef UNPACK_NORM_STATS_EN
  logic [31:0] sub_cnt_q, sub_cnt_d;
  logic [1:0]  sub_inc;
  logic [32:0] sub_sum;

  always_comb begin
    sub_inc   = in_fire ? (2'(is_subnorm(in_op[0])) + 2'(is_subnorm(in_op[1]))) : 2'd0;
    sub_sum   = {1'b0, sub_cnt_q} + 33'(sub_inc);
    sub_cnt_d = sub_sum[32] ? '1 : sub_sum[31:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sub_cnt_q <= '0;
    else       sub_cnt_q <= sub_cnt_d;
  end

  assign sub_cnt = sub_cnt_q;
`endif
endmodule

// File: tb/tb_unpack_normalizer.sv
// Self-checking bench: vector table through a scoreboard queue, plus latency/backpressure/reset sequences.
module tb_unpack_normalizer;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic in_valid = 0, in_ready, db = 0, sa = 0, sb = 0;
  logic [10:0] ea = 0, eb = 0;
  logic [5:0]  lza = 0, lzb = 0;
  logic [52:0] fa = 0, fb = 0, nan = 0;
  logic [3:0]  fla = 0, flb = 0;
  logic out_valid, out_ready = 1, db_o, sa_o, sb_o;
  logic [12:0] xa_o, xb_o;
  logic [52:0] fa_o, fb_o, nan_o;
  logic [3:0]  fla_o, flb_o;
`ifdef UNPACK_NORM_STATS_EN
  logic [31:0] sub_cnt;
`endif

  unpack_normalizer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .db(db), .sa(sa), .sb(sb), .ea(ea), .eb(eb), .lza(lza), .lzb(lzb),
    .fa(fa), .fb(fb), .fla(fla), .flb(flb), .nan(nan),
    .out_valid(out_valid), .out_ready(out_ready),
    .db_o(db_o), .sa_o(sa_o), .sb_o(sb_o), .xa_o(xa_o), .xb_o(xb_o),
    .fa_o(fa_o), .fb_o(fb_o), .fla_o(fla_o), .flb_o(flb_o), .nan_o(nan_o)
`ifdef UNPACK_NORM_STATS_EN
    , .sub_cnt(sub_cnt)
`endif
  );

  typedef struct {
    logic [10:0] e;
    logic [5:0]  lz;
    logic [52:0] f;
    logic [3:0]  fl;
    logic [12:0] x_exp;
    logic [52:0] f_exp;
  } vec_t;

  typedef struct {
    logic db, sa, sb;
    vec_t a, b;
    logic [52:0] nan;
  } pair_t;

  vec_t  tbl[10];
  pair_t sb_q[$];
  pair_t cur;
  int checks = 0, errors = 0, exp_sub = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic pair_t mk(input int i);
    pair_t p;
    p.a   = tbl[i % 10];
    p.b   = tbl[(i + 3) % 10];
    p.sa  = i[0];
    p.sb  = i[1];
    p.db  = i[2];
    p.nan = 53'h08_0000_0000_0000 | 53'(i + 1);
    return p;
  endfunction

  task automatic drive(input pair_t p);
    cur = p;
    in_valid = 1; db = p.db; sa = p.sa; sb = p.sb; nan = p.nan;
    ea = p.a.e; lza = p.a.lz; fa = p.a.f; fla = p.a.fl;
    eb = p.b.e; lzb = p.b.lz; fb = p.b.f; flb = p.b.fl;
  endtask

  task automatic wait_accept(output int cyc);
    bit acc = 0;
    cyc = 0;
    while (!acc && cyc < 30) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        sb_q.push_back(cur);
        if (cur.a.fl == 0 && cur.a.lz != 0) exp_sub++;
        if (cur.b.fl == 0 && cur.b.lz != 0) exp_sub++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic send(input pair_t p, output int w);
    drive(p);
    wait_accept(w);
  endtask

  task automatic lat_test(input pair_t p);
    int w;
    send(p, w);
    chk("lat_accept", w, 1);
    @(negedge clk); chk("lat_c1_valid", out_valid, 0);
    @(negedge clk); chk("lat_c2_valid", out_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1;
    while (sb_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    chk("drain", sb_q.size(), 0);
  endtask

  // Output monitor: pops the scoreboard on each transfer, checks hold-while-stalled.
  initial begin
    pair_t e;
    bit stall = 0;
    logic [12:0] snx;
    logic [52:0] snf, snn;
    forever begin
      @(negedge clk);
      if (reset) stall = 0;
      else begin
        if (stall && out_valid) begin
          chk("stall_xa", xa_o, snx);
          chk("stall_fb", fb_o, snf);
          chk("stall_nan", nan_o, snn);
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) chk("sb_unexpected", 1, 0);
          else begin
            e = sb_q.pop_front();
            chk("xa", xa_o, e.a.x_exp);
            chk("fa", fa_o, e.a.f_exp);
            chk("xb", xb_o, e.b.x_exp);
            chk("fb", fb_o, e.b.f_exp);
            chk("misc", {db_o, sa_o, sb_o, fla_o, flb_o}, {e.db, e.sa, e.sb, e.a.fl, e.b.fl});
            chk("nan", nan_o, e.nan);
          end
        end
        stall = out_valid && !out_ready;
        snx = xa_o; snf = fb_o; snn = nan_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int w, tot;
    tbl[0] = '{11'h400, 6'd0,  53'h18000000000000, 4'h0, 13'h0400, 53'h18000000000000};
    tbl[1] = '{11'h001, 6'd5,  53'h00800000000000, 4'h0, 13'h1FFC, 53'h10000000000000};
    tbl[2] = '{11'h001, 6'd53, 53'h00000000000000, 4'h1, 13'h0000, 53'h00000000000000};
    tbl[3] = '{11'h7FF, 6'd0,  53'h10000000000000, 4'h2, 13'h07FF, 53'h10000000000000};
    tbl[4] = '{11'h7FF, 6'd0,  53'h18000000000000, 4'h4, 13'h07FF, 53'h18000000000000};
    tbl[5] = '{11'h7FF, 6'd2,  53'h04000000000000, 4'h8, 13'h07FF, 53'h04000000000000};
    tbl[6] = '{11'h001, 6'd52, 53'h00000000000001, 4'h0, 13'h1FCD, 53'h10000000000000};
    tbl[7] = '{11'h001, 6'd60, 53'h00000000000001, 4'h0, 13'h1FCD, 53'h10000000000000};
    tbl[8] = '{11'h7FE, 6'd0,  53'h1FFFFFFFFFFFFF, 4'h0, 13'h07FE, 53'h1FFFFFFFFFFFFF};
    tbl[9] = '{11'h001, 6'd1,  53'h0FFFFFFFFFFFFF, 4'h0, 13'h0000, 53'h1FFFFFFFFFFFFE};

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_xa", xa_o, 0);
    chk("rst_fa", fa_o, 0);
    chk("rst_nan", nan_o, 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk); chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Single pair latency
    lat_test(mk(0));
    drain();

    // Full table streamed back-to-back: one accept per cycle
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      send(mk(i), w);
      tot += w;
    end
    chk("stream_cycles", tot, 10);
    drain();

    // Backpressure: two pairs held, third blocked for 4 cycles
    out_ready = 0;
    send(mk(1), w);
    send(mk(4), w);
    drive(mk(7));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1;
    wait_accept(w);
    chk("bp_release_accept", w, 1);
    drain();

    // Async reset with both stages occupied
    out_ready = 0;
    send(mk(8), w);
    send(mk(5), w);
    @(negedge clk); #2 reset = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_fb", fb_o, 0);
    chk("mid_rst_xa", xa_o, 0);
    chk("mid_rst_nan", nan_o, 0);
    sb_q.delete();
    exp_sub = 0;
    @(posedge clk); #1 reset = 0; out_ready = 1;
    lat_test(mk(9));
    drain();

`ifdef UNPACK_NORM_STATS_EN
    chk("sub_cnt", sub_cnt, exp_sub);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
